// File: rtl/stream_pkg.sv
// Shared definitions for the stream arbiter / packet FIFO slice: default widths,
// the buffered beat layout and the packet FIFO write-side states.
package stream_pkg;

    localparam int T_DATA_WIDTH = 8;
    localparam int T_QOS__WIDTH = 4;
    localparam int STREAM_COUNT = 4;

    // A single-stream configuration still needs a 1-bit id field.
    function automatic int id_width(input int streams);
        return (streams > 1) ? $clog2(streams) : 1;
    endfunction

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0]             data;
        logic [T_QOS__WIDTH-1:0]             qos;
        logic [id_width(STREAM_COUNT)-1:0]   id;
        logic                                last;
    } pkt_entry_t;

    typedef enum logic {
        ST_WRITE   = 1'b0,
        ST_DISCARD = 1'b1
    } fifo_state_e;

endpackage

// File: rtl/stream_pkt_fifo_if.sv
// Beat-level valid/ready stream carrying data, QoS, source id and last flag.
interface stream_pkt_fifo_if #(
    parameter int DW = stream_pkg::T_DATA_WIDTH,
    parameter int QW = stream_pkg::T_QOS__WIDTH,
    parameter int IW = stream_pkg::id_width(stream_pkg::STREAM_COUNT)
);

    logic [DW-1:0] data;
    logic [QW-1:0] qos;
    logic [IW-1:0] id;
    logic          last;
    logic          valid;
    logic          ready;

    modport master (
        output data,
        output qos,
        output id,
        output last,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  qos,
        input  id,
        input  last,
        input  valid,
        output ready
    );

endinterface

// File: rtl/stream_pkt_fifo_mem.sv
// Beat storage: one synchronous write port and one asynchronous read port,
// kept separate so it can be replaced by a RAM macro.
module stream_pkt_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_pkt_fifo.sv
// Store-and-forward packet FIFO: beats become visible downstream only once the
// whole packet is stored; packets larger than the buffer are swallowed and flagged.
module stream_pkt_fifo #(
    parameter int T_DATA_WIDTH = stream_pkg::T_DATA_WIDTH,
    parameter int T_QOS__WIDTH = stream_pkg::T_QOS__WIDTH,
    parameter int STREAM_COUNT = stream_pkg::STREAM_COUNT,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    stream_pkt_fifo_if.slave         s_if,
    stream_pkt_fifo_if.master        m_if,
    output logic [$clog2(DEPTH):0]   pkt_count_o,
    output logic                     drop_o
);

    import stream_pkg::*;

    localparam int ID_WIDTH = id_width(STREAM_COUNT);
    localparam int AW       = $clog2(DEPTH);
    localparam int PW       = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic [T_QOS__WIDTH-1:0] qos;
        logic [ID_WIDTH-1:0]     id;
        logic                    last;
    } entry_t;

    fifo_state_e   state_q, state_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] commit_q, commit_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          drop_q, drop_d;

    logic   s_hs;
    logic   m_hs;
    logic   oversize;
    logic   we;
    logic   commit_inc;
    logic   release_dec;
    entry_t wentry;
    entry_t rentry;

    // Ready comes from registered pointers only, so a read in the same cycle
    // never opens the write side.
    assign s_if.ready = (state_q == ST_DISCARD) || ((wr_q - rd_q) != DEPTH_P);
    assign s_hs       = s_if.valid && s_if.ready;

    assign m_if.valid = (rd_q != commit_q);
    assign m_hs       = m_if.valid && m_if.ready;

    // The packet being written already fills the whole buffer and is not ending.
    assign oversize    = (state_q == ST_WRITE) && s_hs && !s_if.last &&
                         ((wr_q + ONE_P - commit_q) == DEPTH_P);
    assign we          = (state_q == ST_WRITE) && s_hs && !oversize;
    assign commit_inc  = we && s_if.last;
    assign release_dec = m_hs && rentry.last;

    assign wentry = {s_if.data, s_if.qos, s_if.id, s_if.last};

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        commit_d = commit_q;
        rd_d     = rd_q;
        drop_d   = 1'b0;

        if (m_hs) begin
            rd_d = rd_q + ONE_P;
        end

        case (state_q)
            ST_WRITE: begin
                if (oversize) begin
                    wr_d    = commit_q;
                    drop_d  = 1'b1;
                    state_d = ST_DISCARD;
                end else if (s_hs) begin
                    wr_d = wr_q + ONE_P;
                    if (s_if.last) begin
                        commit_d = wr_q + ONE_P;
                    end
                end
            end
            ST_DISCARD: begin
                if (s_hs && s_if.last) begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d = ST_WRITE;
            end
        endcase

        cnt_d = cnt_q + PW'(commit_inc) - PW'(release_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_WRITE;
            wr_q     <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            commit_q <= commit_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    stream_pkt_fifo_mem #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_q[AW-1:0]),
        .wdata_i (wentry),
        .raddr_i (rd_q[AW-1:0]),
        .rdata_o (rentry)
    );

    assign m_if.data   = rentry.data;
    assign m_if.qos    = rentry.qos;
    assign m_if.id     = rentry.id;
    assign m_if.last   = rentry.last;
    assign pkt_count_o = cnt_q;
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// Directed scenarios with random beat contents, checked against a queue model of
// committed packets (oversized packets vanish, everything else comes out in order).
module tb_stream_pkt_fifo;

    import stream_pkg::*;

    localparam int DEPTH = 16;
    localparam int IDW   = id_width(STREAM_COUNT);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] pkt_count;
    logic          drop;

    stream_pkt_fifo_if #(.DW(T_DATA_WIDTH), .QW(T_QOS__WIDTH), .IW(IDW)) s_if ();
    stream_pkt_fifo_if #(.DW(T_DATA_WIDTH), .QW(T_QOS__WIDTH), .IW(IDW)) m_if ();

    stream_pkt_fifo #(
        .T_DATA_WIDTH (T_DATA_WIDTH),
        .T_QOS__WIDTH (T_QOS__WIDTH),
        .STREAM_COUNT (STREAM_COUNT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_if        (s_if),
        .m_if        (m_if),
        .pkt_count_o (pkt_count),
        .drop_o      (drop)
    );

    always #5 clk = ~clk;

    int n_cmp     = 0;
    int n_err     = 0;
    int drop_cnt  = 0;
    int out_cnt   = 0;
    int vld_cnt   = 0;
    int acc_cnt   = 0;
    int stall_cnt = 0;

    pkt_entry_t exp_q [$];
    pkt_entry_t pkt_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic int exp_pkts();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].last) n++;
        return n;
    endfunction

    // Output monitor: every valid head beat must be the oldest committed beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (drop) drop_cnt++;
            if (m_if.valid) vld_cnt++;
            check("m_valid_vs_model", 32'(m_if.valid), 32'(exp_q.size() != 0));
            if (m_if.valid && exp_q.size() != 0) begin
                check("head_data", 32'(m_if.data), 32'(exp_q[0].data));
                check("head_qos",  32'(m_if.qos),  32'(exp_q[0].qos));
                check("head_id",   32'(m_if.id),   32'(exp_q[0].id));
                check("head_last", 32'(m_if.last), 32'(exp_q[0].last));
                if (m_if.ready) begin
                    void'(exp_q.pop_front());
                    out_cnt++;
                end
            end
        end
    end

    task automatic mk_rand(input int len);
        logic [IDW-1:0]          id;
        logic [T_QOS__WIDTH-1:0] qos;
        pkt_entry_t              b;
        id  = IDW'($urandom_range(0, STREAM_COUNT - 1));
        qos = T_QOS__WIDTH'($urandom_range(0, 15));
        pkt_q.delete();
        for (int i = 0; i < len; i++) begin
            b.data = T_DATA_WIDTH'($urandom);
            b.qos  = qos;
            b.id   = id;
            b.last = (i == len - 1);
            pkt_q.push_back(b);
        end
    endtask

    task automatic send_beat(input pkt_entry_t b);
        int waited = 0;
        bit acc    = 1'b0;
        s_if.data  = b.data;
        s_if.qos   = b.qos;
        s_if.id    = b.id;
        s_if.last  = b.last;
        s_if.valid = 1'b1;
        do begin
            @(negedge clk);
            acc = s_if.ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                stall_cnt++;
                waited++;
            end
        end while (!acc && waited < 300);
        check("beat_accepted", 32'(acc), 32'(1));
        if (acc) acc_cnt++;
    endtask

    task automatic send_pkt();
        foreach (pkt_q[i]) send_beat(pkt_q[i]);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        if (pkt_q.size() <= DEPTH) begin
            foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
        end
    endtask

    task automatic wait_drain(input string tag, output bit rdy_ok);
        int n = 0;
        rdy_ok = 1'b1;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #2;
            if (!s_if.ready) rdy_ok = 1'b0;
            n++;
        end
        check({tag, "_drained"},   32'(exp_q.size()), 32'(0));
        check({tag, "_pkt_count"}, 32'(pkt_count),    32'(0));
        check({tag, "_m_valid"},   32'(m_if.valid),   32'(0));
    endtask

    task automatic do_reset();
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst_m_valid",   32'(m_if.valid), 32'(0));
        check("rst_s_ready",   32'(s_if.ready), 32'(1));
        check("rst_pkt_count", 32'(pkt_count),  32'(0));
        check("rst_drop",      32'(drop),       32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int         out0, drop0, stall0, vld0, acc0;
        bit         rdy_ok;
        pkt_entry_t b;

        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        s_if.data  = '0;
        s_if.qos   = '0;
        s_if.id    = '0;
        m_if.ready = 1'b0;

        // Reset, then a fixed 3-beat packet with fall-through.
        do_reset();
        m_if.ready = 1'b1;
        pkt_q.delete();
        b.qos = 4'd5;
        b.id  = IDW'(2);
        b.data = 8'hAA; b.last = 1'b0; pkt_q.push_back(b);
        b.data = 8'hBB; b.last = 1'b0; pkt_q.push_back(b);
        b.data = 8'hCC; b.last = 1'b1; pkt_q.push_back(b);
        out0 = out_cnt;
        send_pkt();
        #1;
        check("t1_fallthrough_valid", 32'(m_if.valid), 32'(1));
        check("t1_head_aa",           32'(m_if.data),  32'hAA);
        check("t1_pkt_count_1",       32'(pkt_count),  32'(exp_pkts()));
        wait_drain("t1", rdy_ok);
        check("t1_beats_out", 32'(out_cnt - out0), 32'(3));

        // Two 4-beat packets held, then released.
        m_if.ready = 1'b0;
        out0   = out_cnt;
        stall0 = stall_cnt;
        mk_rand(4); send_pkt();
        mk_rand(4); send_pkt();
        #1;
        check("t2_pkt_count_2", 32'(pkt_count),          32'(exp_pkts()));
        check("t2_no_stall",    32'(stall_cnt - stall0), 32'(0));
        m_if.ready = 1'b1;
        wait_drain("t2", rdy_ok);
        check("t2_ready_held", 32'(rdy_ok),          32'(1));
        check("t2_beats_out",  32'(out_cnt - out0),  32'(8));

        // Oversized packet is dropped whole; a following packet survives.
        m_if.ready = 1'b1;
        out0   = out_cnt;
        drop0  = drop_cnt;
        stall0 = stall_cnt;
        vld0   = vld_cnt;
        mk_rand(DEPTH + 1); send_pkt();
        #1;
        check("t3_drop_once",  32'(drop_cnt - drop0),   32'(1));
        check("t3_no_stall",   32'(stall_cnt - stall0), 32'(0));
        check("t3_pkt_count",  32'(pkt_count),          32'(0));
        check("t3_never_vld",  32'(vld_cnt - vld0),     32'(0));
        mk_rand(2); send_pkt();
        wait_drain("t3", rdy_ok);
        check("t3_beats_out",   32'(out_cnt - out0),   32'(2));
        check("t3_drop_pulsed", 32'(drop_cnt - drop0), 32'(1));

        // Exactly DEPTH beats fit.
        m_if.ready = 1'b0;
        out0   = out_cnt;
        drop0  = drop_cnt;
        stall0 = stall_cnt;
        mk_rand(DEPTH); send_pkt();
        #1;
        check("t4_no_drop",   32'(drop_cnt - drop0),   32'(0));
        check("t4_no_stall",  32'(stall_cnt - stall0), 32'(0));
        check("t4_pkt_count", 32'(pkt_count),          32'(1));
        check("t4_full",      32'(s_if.ready),         32'(0));
        m_if.ready = 1'b1;
        wait_drain("t4", rdy_ok);
        check("t4_beats_out", 32'(out_cnt - out0), 32'(DEPTH));

        // Full with a committed packet pending: stall, not drop.
        m_if.ready = 1'b0;
        out0  = out_cnt;
        drop0 = drop_cnt;
        mk_rand(10); send_pkt();
        #1;
        check("t5_pkt_count_1", 32'(pkt_count), 32'(1));
        mk_rand(8);
        acc0 = acc_cnt;
        fork
            send_pkt();
            begin
                repeat (14) @(posedge clk);
                #2;
                check("t5_accepted_6",   32'(acc_cnt - acc0),   32'(6));
                check("t5_stalled",      32'(s_if.ready),       32'(0));
                check("t5_no_drop",      32'(drop_cnt - drop0), 32'(0));
                check("t5_pkt_count_st", 32'(pkt_count),        32'(1));
                m_if.ready = 1'b1;
            end
        join
        wait_drain("t5", rdy_ok);
        check("t5_beats_out", 32'(out_cnt - out0), 32'(18));
        check("t5_no_drop_end", 32'(drop_cnt - drop0), 32'(0));

        // Reset in the middle of a packet discards the partial beats.
        m_if.ready = 1'b1;
        vld0 = vld_cnt;
        mk_rand(5);
        send_beat(pkt_q[0]);
        send_beat(pkt_q[1]);
        do_reset();
        check("t6_partial_never_vld", 32'(vld_cnt - vld0), 32'(0));
        out0 = out_cnt;
        mk_rand(3); send_pkt();
        wait_drain("t6", rdy_ok);
        check("t6_beats_out", 32'(out_cnt - out0), 32'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
